fetch_controller: RTL and testbench

Sequencer for the IF stage. Owns the fetch PC and drives the IF stage's pc_in, stall and flush inputs.
- Holds fetch during a post-reset boot window.
- Steps the PC by 4 each cycle.
- Freezes on load-use hazards.
- Redirects on resolved branches/jumps, with a one-cycle flush.
- Halts on a syscall instruction until software or the bench pulses run.

---
 rtl/fetch_ctrl_pkg.sv | 13 +
 rtl/fetch_controller.sv | 154 +++++++++++++++
 tb/tb_fetch_controller.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the IF-stage fetch sequencer.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] SYSCALL_WORD = 32'h0000_000C;

endpackage

// File: rtl/fetch_controller.sv
// Fetch PC sequencer: boot hold, +4 stepping, hazard freeze, redirect with
// one-cycle flush, and halt on a syscall word until a run pulse arrives.
module fetch_controller
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES = 2,
  parameter logic [31:0] HALT_INSTR  = SYSCALL_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] instruction_in,
  input  logic        run,
  output logic [31:0] pc_in,
  output logic        stall,
  output logic        flush,
  output logic        halted,
  output logic        err_misaligned,
  output logic [31:0] fetch_count
);

  localparam int unsigned BOOT_W    = (BOOT_CYCLES < 1) ? 1 : $clog2(BOOT_CYCLES + 1);
  localparam int unsigned BOOT_LAST = (BOOT_CYCLES == 0) ? 0 : BOOT_CYCLES - 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST_W = BOOT_W'(BOOT_LAST);

  fetch_state_t      state_q, state_d;
  logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic [31:0]       pc_q, pc_d;
  logic              stall_q, stall_d;
  logic              flush_q, flush_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;
  logic [31:0]       fetch_count_q, fetch_count_d;
  logic              advance;
  logic              boot_done;

  // A zero-length boot window still spends the first edge after release in BOOT.
  assign boot_done = (boot_cnt_q == BOOT_LAST_W);

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc_q;
    stall_d    = stall_q;
    flush_d    = flush_q;
    halted_d   = halted_q;
    err_d      = err_q;
    advance    = 1'b0;

    case (state_q)
      BOOT: begin
        boot_cnt_d = boot_cnt_q + 1'b1;
        stall_d    = 1'b1;
        flush_d    = 1'b1;
        if (boot_done) begin
          state_d = RUN;
          stall_d = 1'b0;
          flush_d = 1'b0;
        end
      end

      RUN: begin
        if (redirect_valid) begin
          pc_d    = {redirect_pc[31:2], 2'b00};
          flush_d = 1'b1;
          stall_d = 1'b0;
          advance = 1'b1;
          if (redirect_pc[1:0] != 2'b00) begin
            err_d = 1'b1;
          end
        end else if (hazard_stall) begin
          stall_d = 1'b1;
          flush_d = 1'b0;
        // A halt word seen right after a stall or flush is not a real fetch.
        end else if ((instruction_in == HALT_INSTR) && !stall_q && !flush_q) begin
          state_d  = HALT;
          halted_d = 1'b1;
          stall_d  = 1'b1;
          flush_d  = 1'b0;
        end else begin
          pc_d    = pc_q + PC_STEP;
          stall_d = 1'b0;
          flush_d = 1'b0;
          advance = 1'b1;
        end
      end

      HALT: begin
        stall_d  = 1'b1;
        flush_d  = 1'b0;
        halted_d = 1'b1;
        if (run) begin
          state_d  = RUN;
          halted_d = 1'b0;
          stall_d  = 1'b0;
          pc_d     = pc_q + PC_STEP;
          advance  = 1'b1;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase

    fetch_count_d = (advance && (fetch_count_q != 32'hFFFF_FFFF)) ?
                    fetch_count_q + 32'd1 : fetch_count_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      stall_q  <= 1'b1;
      flush_q  <= 1'b1;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      boot_cnt_q <= '0;
    end else begin
      boot_cnt_q <= boot_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign pc_in          = pc_q;
  assign stall          = stall_q;
  assign flush          = flush_q;
  assign halted         = halted_q;
  assign err_misaligned = err_q;
  assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: directed walk through boot, hazard,
// redirect, halt and wrap, then randomized traffic against a behavioural model.
module tb_fetch_controller;

  localparam logic [31:0] HALT_WORD = 32'h0000_000C;
  localparam int          BOOT_LEN  = 2;

  typedef struct {
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        halted;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instruction_in;
  logic        run;
  logic [31:0] pc_in;
  logic        stall;
  logic        flush;
  logic        halted;
  logic        err_misaligned;
  logic [31:0] fetch_count;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model: fetch position plus a few flags, stepped one edge at a time.
  logic [31:0] m_pc;
  logic        m_stall, m_flush, m_halted, m_err;
  logic [31:0] m_cnt;
  int          m_boot_left;

  fetch_controller #(
    .RESET_PC   (32'h0000_0000),
    .BOOT_CYCLES(BOOT_LEN),
    .HALT_INSTR (HALT_WORD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .hazard_stall  (hazard_stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instruction_in(instruction_in),
    .run           (run),
    .pc_in         (pc_in),
    .stall         (stall),
    .flush         (flush),
    .halted        (halted),
    .err_misaligned(err_misaligned),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic resetModel();
    m_pc        = 32'h0;
    m_stall     = 1'b1;
    m_flush     = 1'b1;
    m_halted    = 1'b0;
    m_err       = 1'b0;
    m_cnt       = 32'h0;
    m_boot_left = (BOOT_LEN == 0) ? 1 : BOOT_LEN;
  endtask

  task automatic bumpCount();
    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
  endtask

  task automatic modelStep(input logic r, input logic hz, input logic rv,
                           input logic [31:0] rpc, input logic [31:0] instr, input logic rn);
    if (!r) begin
      resetModel();
    end else if (m_boot_left > 0) begin
      m_boot_left--;
      m_stall = (m_boot_left != 0);
      m_flush = (m_boot_left != 0);
    end else if (m_halted) begin
      if (rn) begin
        m_halted = 1'b0;
        m_pc     = m_pc + 4;
        m_stall  = 1'b0;
        m_flush  = 1'b0;
        bumpCount();
      end
    end else if (rv) begin
      m_pc    = rpc & 32'hFFFF_FFFC;
      m_flush = 1'b1;
      m_stall = 1'b0;
      if ((rpc % 4) != 0) m_err = 1'b1;
      bumpCount();
    end else if (hz) begin
      m_stall = 1'b1;
      m_flush = 1'b0;
    end else if (instr == HALT_WORD && !m_stall && !m_flush) begin
      m_halted = 1'b1;
      m_stall  = 1'b1;
      m_flush  = 1'b0;
    end else begin
      m_pc    = m_pc + 4;
      m_stall = 1'b0;
      m_flush = 1'b0;
      bumpCount();
    end
  endtask

  task automatic applyStimulus(input logic r, input logic hz, input logic rv,
                               input logic [31:0] rpc, input logic [31:0] instr, input logic rn);
    exp_t e;
    @(negedge clk);
    rst            = r;
    hazard_stall   = hz;
    redirect_valid = rv;
    redirect_pc    = rpc;
    instruction_in = instr;
    run            = rn;
    modelStep(r, hz, rv, rpc, instr, rn);
    e.pc     = m_pc;
    e.stall  = m_stall;
    e.flush  = m_flush;
    e.halted = m_halted;
    e.err    = m_err;
    e.cnt    = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // Monitor: every output update after an edge is checked against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("pc_in", pc_in, e.pc);
        checkOutput("stall", 32'(stall), 32'(e.stall));
        checkOutput("flush", 32'(flush), 32'(e.flush));
        checkOutput("halted", 32'(halted), 32'(e.halted));
        checkOutput("err_misaligned", 32'(err_misaligned), 32'(e.err));
        checkOutput("fetch_count", fetch_count, e.cnt);
      end
    end
  end

  initial begin
    logic        hz, rv, rn, rr;
    logic [31:0] rpc, instr;

    rst            = 1'b0;
    hazard_stall   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instruction_in = 32'h0;
    run            = 1'b0;
    resetModel();

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(6);                                                   // boot, then 0,4,8,12,0x10
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);       // hazard freeze at 0x10
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(2);                                                   // 0x14, 0x18
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 1'b0);      // redirect to 0x40
    idle(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h83, HALT_WORD, 1'b0);  // redirect beats hazard and halt
    idle(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 1'b0);
    idle(1);                                                   // pc 0x24, no stall/flush
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, HALT_WORD, 1'b0);   // halt at 0x24
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, i[0], ~i[0], 32'h100, HALT_WORD, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);       // resume to 0x28
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0);
    idle(2);                                                   // wrap to 0, then 4

    // Mid-cycle asynchronous reset must act without a clock edge.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    resetModel();
    checkOutput("async_pc_in", pc_in, 32'h0);
    checkOutput("async_stall", 32'(stall), 32'd1);
    checkOutput("async_flush", 32'(flush), 32'd1);
    checkOutput("async_halted", 32'(halted), 32'd0);
    checkOutput("async_err", 32'(err_misaligned), 32'd0);
    checkOutput("async_count", fetch_count, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(3);

    for (int i = 0; i < 600; i++) begin
      rr    = ($urandom_range(199) != 0);
      hz    = ($urandom_range(99) < 20);
      rv    = ($urandom_range(99) < 15);
      rn    = ($urandom_range(99) < 20);
      rpc   = $urandom();
      if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
      instr = ($urandom_range(99) < 20) ? HALT_WORD : $urandom();
      applyStimulus(rr, hz, rv, rpc, instr, rn);
    end

    idle(2);
    @(posedge clk);
    #2;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
